// File: rtl/aes_cbc_ctrl.sv
// CBC sequencer for aes_core: key expansion, per-block chaining XOR, output buffering and core watchdog.
// Optional build macro AES_CBC_ECB_EN adds cfg_ecb, which bypasses all chaining when latched high.
module aes_cbc_ctrl #(
  parameter int WAIT_TIMEOUT = 1023,
  parameter int TO_W         = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_start,
  input  logic [255:0] cfg_key,
  input  logic         cfg_keylen,
  input  logic         cfg_enc_dec,
  input  logic [127:0] cfg_iv,
`ifdef AES_CBC_ECB_EN
  input  logic         cfg_ecb,
`endif
  output logic         cfg_busy,
  output logic         err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         core_init,
  output logic         core_next,
  output logic         core_enc_dec,
  output logic         core_keylen,
  output logic [255:0] core_key,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic [127:0] core_result,
  input  logic         core_result_valid
);

  typedef enum logic [2:0] {
    S_UNCONF = 3'd0,
    S_KINIT  = 3'd1,
    S_KWAIT  = 3'd2,
    S_IDLE   = 3'd3,
    S_NEXT   = 3'd4,
    S_BWAIT  = 3'd5,
    S_OUT    = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] WD_MAX = TO_W'(WAIT_TIMEOUT);

  state_t          state_q, state_d;
  logic [255:0]    key_q, key_d;
  logic            keylen_q, keylen_d, enc_q, enc_d;
  logic [127:0]    iv_q, iv_d, chain_q, chain_d, blk_q, blk_d;
  logic [127:0]    din_q, din_d, out_q, out_d;
  logic            last_q, last_d, out_last_q, out_last_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            err_q, err_d, busy_q, busy_d;
  logic            init_q, init_d, next_q, next_d, ov_q, ov_d;
  logic            cfg_ok_s, ecb_s, in_ready_s;

  assign cfg_ok_s = cfg_start && (state_q inside {S_UNCONF, S_IDLE, S_ERR});

`ifdef AES_CBC_ECB_EN
  logic ecb_q, ecb_d;
  always_comb begin
    ecb_d = ecb_q;
    if (cfg_ok_s) begin
      ecb_d = cfg_ecb;
    end else begin
      ecb_d = ecb_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) ecb_q <= 1'b0;
    else       ecb_q <= ecb_d;
  end
  assign ecb_s = ecb_q;
`else
  assign ecb_s = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    keylen_d   = keylen_q;
    enc_d      = enc_q;
    iv_d       = iv_q;
    chain_d    = chain_q;
    blk_d      = blk_q;
    din_d      = din_q;
    out_d      = out_q;
    last_d     = last_q;
    out_last_d = out_last_q;
    wd_d       = wd_q;
    err_d      = err_q;
    in_ready_s = 1'b0;
    case (state_q)
      S_KINIT: begin
        wd_d    = '0;
        state_d = S_KWAIT;
      end
      S_KWAIT: begin
        if (core_ready) begin
          state_d = S_IDLE;
        end else if (wd_q == WD_MAX) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      S_IDLE: begin
        in_ready_s = !cfg_start;
        if (in_valid && !cfg_start) begin
          din_d   = in_data;
          last_d  = in_last;
          blk_d   = (enc_q && !ecb_s) ? (in_data ^ chain_q) : in_data;
          state_d = S_NEXT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_NEXT: begin
        wd_d    = '0;
        state_d = S_BWAIT;
      end
      S_BWAIT: begin
        if (core_ready && core_result_valid) begin
          out_d      = (enc_q || ecb_s) ? core_result : (core_result ^ chain_q);
          out_last_d = last_q;
          if (ecb_s)       chain_d = chain_q;
          else if (last_q) chain_d = iv_q;
          else if (enc_q)  chain_d = core_result;
          else             chain_d = din_q;
          state_d = S_OUT;
        end else if (core_ready || (wd_q == WD_MAX)) begin
          // ready without result_valid is a core protocol violation: handled like a hang
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
        else           state_d = S_OUT;
      end
      S_UNCONF, S_ERR: state_d = state_q;
      default:         state_d = S_UNCONF;
    endcase
    if (cfg_ok_s) begin
      key_d    = cfg_key;
      keylen_d = cfg_keylen;
      enc_d    = cfg_enc_dec;
      iv_d     = cfg_iv;
      chain_d  = cfg_iv;
      err_d    = 1'b0;
      state_d  = S_KINIT;
    end else begin
      err_d = err_d;
    end
    init_d = (state_d == S_KINIT);
    next_d = (state_d == S_NEXT);
    ov_d   = (state_d == S_OUT);
    busy_d = !(state_d inside {S_UNCONF, S_IDLE, S_ERR});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_UNCONF;
      key_q      <= 256'd0;
      keylen_q   <= 1'b0;
      enc_q      <= 1'b0;
      iv_q       <= 128'd0;
      chain_q    <= 128'd0;
      blk_q      <= 128'd0;
      din_q      <= 128'd0;
      out_q      <= 128'd0;
      last_q     <= 1'b0;
      out_last_q <= 1'b0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      init_q     <= 1'b0;
      next_q     <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      keylen_q   <= keylen_d;
      enc_q      <= enc_d;
      iv_q       <= iv_d;
      chain_q    <= chain_d;
      blk_q      <= blk_d;
      din_q      <= din_d;
      out_q      <= out_d;
      last_q     <= last_d;
      out_last_q <= out_last_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      init_q     <= init_d;
      next_q     <= next_d;
      ov_q       <= ov_d;
    end
  end

  assign in_ready     = in_ready_s;
  assign cfg_busy     = busy_q;
  assign err          = err_q;
  assign out_valid    = ov_q;
  assign out_data     = out_q;
  assign out_last     = out_last_q;
  assign core_init    = init_q;
  assign core_next    = next_q;
  assign core_enc_dec = enc_q;
  assign core_keylen  = keylen_q;
  assign core_key     = key_q;
  assign core_block   = blk_q;

endmodule
